// File: rtl/dwconv_pkg.sv
// Shared definitions for the depthwise 1-D INT8 convolution blocks:
// FSM state encoding, configuration address map and requantisation helpers.
package dwconv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  // Config address of weight W[c][k]; biases follow the C*K weight words.
  function automatic int wgt_addr(input int c, input int k, input int taps);
    return c * taps + k;
  endfunction

  function automatic int bias_addr(input int c, input int chans, input int taps);
    return chans * taps + c;
  endfunction

  // Round-to-nearest arithmetic right shift; shifts at or beyond the
  // accumulator width collapse to the sign (0 or -1).
  function automatic logic signed [63:0] rshift_round(input logic signed [63:0] acc,
                                                      input int sh, input int accw);
    logic signed [64:0] t;
    if (sh == 0) return acc;
    if (sh >= accw) return acc[63] ? -64'sd1 : 64'sd0;
    t = {acc[63], acc} + (65'sd1 <<< (sh - 1));
    t = t >>> sh;
    return t[63:0];
  endfunction

  // Optional ReLU followed by clamp to the signed 8-bit range.
  function automatic logic signed [7:0] sat8(input logic signed [63:0] v, input logic relu);
    if (relu && (v < 0)) return 8'sd0;
    if (v > 64'sd127) return 8'sd127;
    if (v < -64'sd128) return 8'h80;
    return v[7:0];
  endfunction

endpackage

// File: rtl/dwconv_requant.sv
// Combinational requantiser: accumulator -> rounded, shifted, ReLU'd, saturated int8.
module dwconv_requant
  import dwconv_pkg::*;
#(
  parameter int ACCW = 32,
  parameter int SHW  = 5
) (
  input  logic signed [ACCW-1:0] acc_i,
  input  logic [SHW-1:0]         shift_i,
  input  logic                   relu_i,
  output logic [7:0]             q_o
);

  logic signed [63:0] v;

  // Round/shift in a wide domain, then clamp to int8.
  always_comb begin
    v   = rshift_round(64'(acc_i), int'(shift_i), ACCW);
    q_o = sat8(v, relu_i);
  end

endmodule

// File: rtl/dwconv1d_int8_stream.sv
// Streaming depthwise 1-D convolution: per-channel K-tap windows, one MAC per
// cycle (channel-major, tap-minor), requantised int8 output beat per window.
module dwconv1d_int8_stream
  import dwconv_pkg::*;
#(
  parameter int C        = 4,
  parameter int K        = 3,
  parameter int ACCW     = 32,
  parameter int PAD_SAME = 0,
  parameter int SHW      = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(C*K+C)-1:0]     cfg_addr,
  input  logic [ACCW-1:0]              cfg_wdata,
  input  logic [SHW-1:0]               cfg_shift,
  input  logic                         cfg_relu,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [C*8-1:0]               s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [C*8-1:0]               m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         short_frm
);

  localparam int NW = bias_addr(0, C, K);
  localparam int NA = bias_addr(C, C, K);
  localparam int AW = $clog2(C*K+C);
  localparam int P  = (PAD_SAME != 0) ? (K - 1) / 2 : 0;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int FW = $clog2(K + 1);
  localparam int PW = (P > 0) ? $clog2(P + 1) : 1;

  state_e                 state_q;
  logic                   rdy_q, busy_q, short_q, mvalid_q, mlast_q, winlast_q;
  logic [C*8-1:0]         mdata_q;
  logic [FW-1:0]          fill_q;
  logic [PW-1:0]          flush_q;
  logic [CW-1:0]          ch_q, pend_ch_q;
  logic [KW-1:0]          tap_q;
  logic [WW-1:0]          widx_q;
  logic                   mac_done_q, pend_q;
  logic signed [ACCW-1:0] acc_q;
  logic [SHW-1:0]         shift_q;
  logic                   relu_q;

  logic signed [7:0]      wgt_q  [NW];
  logic signed [ACCW-1:0] bias_q [C];

  logic                   accept, first, win_shift, win_clr, win_zero;
  logic [FW-1:0]          fill_base, fill_d;
  logic [C*8-1:0]         tapx;
  logic signed [7:0]      x, w;
  logic signed [15:0]     prod;
  logic signed [ACCW-1:0] acc_d;
  logic [7:0]             rq;
  logic [AW-1:0]          baddr;

  assign accept    = (state_q == IDLE) && rdy_q && s_valid;
  assign first     = !busy_q;
  assign win_shift = accept || (state_q == FLUSH);
  assign win_clr   = accept && first;
  assign win_zero  = (state_q == FLUSH);
  assign baddr     = cfg_addr - AW'(NW);

  // Window occupancy after this shift: a new frame starts with the leading pads.
  assign fill_base = (accept && first) ? FW'(P) : fill_q;
  assign fill_d    = (fill_base >= FW'(K)) ? FW'(K) : fill_base + 1'b1;

  for (genvar gi = 0; gi < C; gi++) begin : g_win
    logic [7:0] win_q [K];

    // Shift a new sample (or a tail pad zero) into this channel's window, oldest at tap 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < K; k++) win_q[k] <= '0;
      end else if (win_shift) begin
        for (int k = 0; k < K - 1; k++) win_q[k] <= win_clr ? 8'd0 : win_q[k+1];
        win_q[K-1] <= win_zero ? 8'd0 : s_data[8*gi +: 8];
      end
    end

    assign tapx[8*gi +: 8] = win_q[tap_q];
  end

  // One MAC: the first tap of a channel restarts from that channel's bias.
  always_comb begin
    x     = tapx[{ch_q, 3'b000} +: 8];
    w     = wgt_q[widx_q];
    prod  = x * w;
    acc_d = ((tap_q == '0) ? bias_q[ch_q] : acc_q) + ACCW'(prod);
  end

  dwconv_requant #(.ACCW(ACCW), .SHW(SHW)) u_requant (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .q_o     (rq)
  );

  // Coefficient register file; writes land only between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) wgt_q[i] <= '0;
      for (int i = 0; i < C; i++) bias_q[i] <= '0;
    end else if (cfg_we && !busy_q) begin
      if (int'(cfg_addr) < NW) wgt_q[cfg_addr[WW-1:0]] <= cfg_wdata[7:0];
      else if (int'(cfg_addr) < NA) bias_q[baddr[CW-1:0]] <= cfg_wdata;
    end
  end

  // Frame control FSM with registered handshake/status outputs and MAC sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;      rdy_q <= 1'b0;   busy_q <= 1'b0;    short_q <= 1'b0;
      mvalid_q <= 1'b0;     mlast_q <= 1'b0; mdata_q <= '0;     winlast_q <= 1'b0;
      fill_q <= '0;         flush_q <= '0;   ch_q <= '0;        tap_q <= '0;
      widx_q <= '0;         pend_q <= 1'b0;  pend_ch_q <= '0;   mac_done_q <= 1'b0;
      acc_q <= '0;          shift_q <= '0;   relu_q <= 1'b0;
    end else begin
      short_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            fill_q <= fill_d;
            if (first) begin
              busy_q  <= 1'b1;
              shift_q <= cfg_shift;
              relu_q  <= cfg_relu;
              flush_q <= '0;
            end
            if (fill_d == FW'(K)) begin
              state_q <= COMPUTE; rdy_q <= 1'b0;
              ch_q <= '0; tap_q <= '0; widx_q <= '0; mac_done_q <= 1'b0; pend_q <= 1'b0;
              winlast_q <= s_last && (P == 0);
              if (s_last) flush_q <= PW'(P);
            end else if (s_last) begin
              if (P == 0) begin
                short_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= FLUSH; rdy_q <= 1'b0;
                flush_q <= PW'(P);
              end
            end
          end
        end
        COMPUTE: begin
          if (pend_q) mdata_q[{pend_ch_q, 3'b000} +: 8] <= rq;
          pend_q <= 1'b0;
          if (!mac_done_q) begin
            acc_q  <= acc_d;
            widx_q <= widx_q + 1'b1;
            if (tap_q == KW'(K - 1)) begin
              pend_q <= 1'b1; pend_ch_q <= ch_q; tap_q <= '0;
              if (ch_q == CW'(C - 1)) begin
                mac_done_q <= 1'b1; ch_q <= '0;
              end else begin
                ch_q <= ch_q + 1'b1;
              end
            end else begin
              tap_q <= tap_q + 1'b1;
            end
          end else begin
            mac_done_q <= 1'b0;
            state_q <= OUT; mvalid_q <= 1'b1; mlast_q <= winlast_q;
          end
        end
        OUT: begin
          if (m_ready) begin
            mvalid_q <= 1'b0; mlast_q <= 1'b0;
            if (flush_q != '0) begin
              state_q <= FLUSH;
            end else begin
              state_q <= IDLE; rdy_q <= 1'b1;
              if (mlast_q) busy_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          fill_q  <= fill_d;
          flush_q <= flush_q - 1'b1;
          if (fill_d == FW'(K)) begin
            state_q <= COMPUTE;
            ch_q <= '0; tap_q <= '0; widx_q <= '0; mac_done_q <= 1'b0; pend_q <= 1'b0;
            winlast_q <= (flush_q == PW'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = rdy_q;
  assign m_valid   = mvalid_q;
  assign m_data    = mdata_q;
  assign m_last    = mlast_q;
  assign busy      = busy_q;
  assign short_frm = short_q;

endmodule
